// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the mm:ss stopwatch / countdown timer.
package stopwatch_pkg;

    // Controller states; the numeric values are visible on the state output.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } sw_state_e;

    // Largest legal value of a units digit and of a tens digit in mm:ss.
    localparam logic [3:0] UNITS_MAX = 4'd9;
    localparam logic [3:0] TENS_MAX  = 4'd5;

    // Four packed BCD digits {min_tens, min_units, sec_tens, sec_units}.
    typedef logic [15:0] bcd_time_t;

    localparam bcd_time_t TIME_ZERO = 16'h0000;
    localparam bcd_time_t TIME_MAX  = 16'h5959;

    // Limit one BCD digit to dmax.
    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] dmax);
        return (d > dmax) ? dmax : d;
    endfunction

    // Force an arbitrary 16-bit preset into a legal mm:ss value, digit by digit.
    function automatic bcd_time_t clamp_time(input bcd_time_t t);
        return {clamp_digit(t[15:12], TENS_MAX),
                clamp_digit(t[11:8],  UNITS_MAX),
                clamp_digit(t[7:4],   TENS_MAX),
                clamp_digit(t[3:0],   UNITS_MAX)};
    endfunction

endpackage

// File: rtl/bcd_mmss_counter.sv
// Four-digit BCD mm:ss up/down counter with clear and load.
// value_nxt exposes the value the register takes at the next edge so the
// parent can register its display on that same edge.
module bcd_mmss_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        dir,
    input  logic        ld,
    input  logic [15:0] ld_val,
    input  logic        clr,
    output logic [15:0] value,
    output logic [15:0] value_nxt,
    output logic        is_zero,
    output logic        rollover
);
    import stopwatch_pkg::*;

    bcd_time_t  value_q;
    bcd_time_t  value_d;
    bcd_time_t  step;
    logic [3:0] su, st, mu, mt;
    logic [3:0] su_n, st_n, mu_n, mt_n;

    assign {mt, mu, st, su} = value_q;

    // One-step neighbour of the current value: carries (up) or borrows (down) ripple from sec units upward.
    always_comb begin
        // NOTE: every variable written here is given a default first, so no path can leave it unassigned and infer a latch.
        su_n = su;
        st_n = st;
        mu_n = mu;
        mt_n = mt;
        if (!dir) begin
            if (su != UNITS_MAX) begin
                su_n = su + 4'd1;
            end else begin
                su_n = 4'd0;
                if (st != TENS_MAX) begin
                    st_n = st + 4'd1;
                end else begin
                    st_n = 4'd0;
                    if (mu != UNITS_MAX) begin
                        mu_n = mu + 4'd1;
                    end else begin
                        mu_n = 4'd0;
                        mt_n = (mt != TENS_MAX) ? mt + 4'd1 : 4'd0;
                    end
                end
            end
        end else begin
            if (su != 4'd0) begin
                su_n = su - 4'd1;
            end else begin
                su_n = UNITS_MAX;
                if (st != 4'd0) begin
                    st_n = st - 4'd1;
                end else begin
                    st_n = TENS_MAX;
                    if (mu != 4'd0) begin
                        mu_n = mu - 4'd1;
                    end else begin
                        mu_n = UNITS_MAX;
                        mt_n = (mt != 4'd0) ? mt - 4'd1 : TENS_MAX;
                    end
                end
            end
        end
    end

    assign step = {mt_n, mu_n, st_n, su_n};

    // Select the next value: clear beats load beats a counting step.
    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = TIME_ZERO;
        end else if (ld) begin
            value_d = ld_val;
        end else if (en) begin
            value_d = step;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            value_q <= TIME_ZERO;
        end else begin
            value_q <= value_d;
        end
    end

    assign value     = value_q;
    assign value_nxt = value_d;
    assign is_zero   = (value_q == TIME_ZERO);
    assign rollover  = en && !clr && !ld && !dir && (value_q == TIME_MAX);

endmodule

// File: rtl/stopwatch_timer_ctrl.sv
// mm:ss stopwatch / countdown timer controller: prescaler, run-state FSM,
// lap freeze, alarm window and registered display outputs.
// A command that has no effect in the current state (e.g. load while running)
// does not mask lower-priority commands arriving in the same cycle.
module stopwatch_timer_ctrl #(
    parameter int CLK_HZ      = 50_000_000,
    parameter int TICK_HZ     = 1,
    parameter int ALARM_TICKS = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        pause,
    input  logic        clear,
    input  logic        load,
    input  logic        mode,
    input  logic        lap,
    input  logic [15:0] preset,
    output logic [15:0] digits,
    output logic [1:0]  state,
    output logic        running,
    output logic        wrap,
    output logic        alarm,
    output logic        lap_active,
    output logic        tick_led
);
    import stopwatch_pkg::*;

    localparam int                DIV        = CLK_HZ / TICK_HZ;
    localparam int                PSC_W      = $clog2(DIV);
    localparam logic [PSC_W-1:0]  PSC_LAST   = PSC_W'(DIV - 1);
    localparam int                ACNT_W     = $clog2(ALARM_TICKS + 1);
    localparam logic [ACNT_W-1:0] ALARM_LAST = ACNT_W'(ALARM_TICKS - 1);

    sw_state_e         state_q, state_d;
    logic              mode_q, mode_d;
    logic [PSC_W-1:0]  psc_q, psc_d;
    logic              lap_q, lap_d;
    bcd_time_t         cap_q, cap_d;
    logic              alarm_q, alarm_d;
    logic [ACNT_W-1:0] acnt_q, acnt_d;
    logic              led_q, led_d;
    logic              wrap_q, wrap_d;
    bcd_time_t         digits_q, digits_d;
    logic              running_q, running_d;

    logic      tick;
    logic      cnt_en, cnt_ld, cnt_clr;
    bcd_time_t cnt_value, cnt_value_nxt;
    logic      cnt_zero, cnt_rollover;

    assign tick = (psc_q == PSC_LAST);

    bcd_mmss_counter u_counter (
        .clk       (clk),
        .rst       (rst),
        .en        (cnt_en),
        .dir       (mode_q),
        .ld        (cnt_ld),
        .ld_val    (clamp_time(preset)),
        .clr       (cnt_clr),
        .value     (cnt_value),
        .value_nxt (cnt_value_nxt),
        .is_zero   (cnt_zero),
        .rollover  (cnt_rollover)
    );

    // Next-state logic: command priority clear > load > pause > start > lap, then tick effects.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        psc_d   = psc_q;
        lap_d   = lap_q;
        cap_d   = cap_q;
        alarm_d = alarm_q;
        acnt_d  = acnt_q;
        led_d   = led_q;
        cnt_en  = 1'b0;
        cnt_ld  = 1'b0;
        cnt_clr = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                psc_d = '0;
                if (clear) begin
                    cnt_clr = 1'b1;
                end else if (load) begin
                    cnt_ld = 1'b1;
                end else if (start && !(mode && cnt_zero)) begin
                    // A countdown from 00:00 has nothing to count, so it never starts.
                    state_d = ST_RUN;
                    mode_d  = mode;
                end
            end

            ST_RUN: begin
                if (clear) begin
                    state_d = ST_IDLE;
                    cnt_clr = 1'b1;
                    psc_d   = '0;
                    lap_d   = 1'b0;
                end else begin
                    // The cycle that takes the pause is still a RUN cycle and keeps its tick.
                    psc_d = tick ? '0 : psc_q + PSC_W'(1);
                    if (pause) begin
                        state_d = ST_PAUSE;
                    end else if (lap) begin
                        lap_d = !lap_q;
                        if (!lap_q) begin
                            cap_d = cnt_value;
                        end
                    end
                    if (tick) begin
                        led_d = !led_q;
                        if (mode_q && cnt_zero) begin
                            // Expiry wins over a same-cycle pause: the time has already run out.
                            state_d = ST_DONE;
                            alarm_d = 1'b1;
                            acnt_d  = '0;
                            lap_d   = 1'b0;
                        end else begin
                            cnt_en = 1'b1;
                        end
                    end
                end
            end

            ST_PAUSE: begin
                if (clear || load) begin
                    state_d = ST_IDLE;
                    cnt_clr = clear;
                    cnt_ld  = !clear;
                    psc_d   = '0;
                    lap_d   = 1'b0;
                end else if (start) begin
                    state_d = ST_RUN;
                end
            end

            ST_DONE: begin
                if (clear || load) begin
                    state_d = ST_IDLE;
                    cnt_clr = clear;
                    cnt_ld  = !clear;
                    psc_d   = '0;
                    alarm_d = 1'b0;
                    acnt_d  = '0;
                end else begin
                    psc_d = tick ? '0 : psc_q + PSC_W'(1);
                    if (tick) begin
                        led_d = !led_q;
                        if (alarm_q) begin
                            if (acnt_q == ALARM_LAST) begin
                                alarm_d = 1'b0;
                            end else begin
                                acnt_d = acnt_q + ACNT_W'(1);
                            end
                        end
                    end
                end
            end
        endcase
    end

    // Output values computed from next state so every output changes on the same edge as the count.
    always_comb begin
        wrap_d    = cnt_rollover;
        digits_d  = lap_d ? cap_d : cnt_value_nxt;
        running_d = (state_d == ST_RUN);
    end

    // Controller and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            mode_q    <= 1'b0;
            psc_q     <= '0;
            lap_q     <= 1'b0;
            cap_q     <= TIME_ZERO;
            alarm_q   <= 1'b0;
            acnt_q    <= '0;
            led_q     <= 1'b0;
            wrap_q    <= 1'b0;
            digits_q  <= TIME_ZERO;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            psc_q     <= psc_d;
            lap_q     <= lap_d;
            cap_q     <= cap_d;
            alarm_q   <= alarm_d;
            acnt_q    <= acnt_d;
            led_q     <= led_d;
            wrap_q    <= wrap_d;
            digits_q  <= digits_d;
            running_q <= running_d;
        end
    end

    assign digits     = digits_q;
    assign state      = state_q;
    assign running    = running_q;
    assign wrap       = wrap_q;
    assign alarm      = alarm_q;
    assign lap_active = lap_q;
    assign tick_led   = led_q;

endmodule

// File: tb/tb_stopwatch_timer_ctrl.sv
// Bench for stopwatch_timer_ctrl: directed scenarios followed by random
// command traffic, scored against a seconds-based reference model.
module tb_stopwatch_timer_ctrl;

    localparam int DIV         = 10;
    localparam int ALARM_TICKS = 2;
    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, pause = 1'b0, clear = 1'b0, load = 1'b0, mode = 1'b0, lap = 1'b0;
    logic [15:0] preset = 16'h0000;
    logic [15:0] digits;
    logic [1:0]  state;
    logic        running, wrap, alarm, lap_active, tick_led;

    stopwatch_timer_ctrl #(
        .CLK_HZ      (10),
        .TICK_HZ     (1),
        .ALARM_TICKS (ALARM_TICKS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pause      (pause),
        .clear      (clear),
        .load       (load),
        .mode       (mode),
        .lap        (lap),
        .preset     (preset),
        .digits     (digits),
        .state      (state),
        .running    (running),
        .wrap       (wrap),
        .alarm      (alarm),
        .lap_active (lap_active),
        .tick_led   (tick_led)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected outputs after one clock edge.
    typedef struct packed {
        logic [15:0] digits;
        logic [1:0]  state;
        logic        running;
        logic        wrap;
        logic        alarm;
        logic        lap_active;
        logic        tick_led;
    } exp_t;

    exp_t sb_q[$];

    // Reference model: time kept as whole seconds, prescaler as an integer fraction.
    int m_state, m_secs, m_cap, m_psc, m_acnt;
    bit m_mode, m_lap, m_alarm, m_wrap, m_led;

    function automatic int clamp_secs(input logic [15:0] p);
        int d[4];
        int lim[4];
        lim[0] = 5; lim[1] = 9; lim[2] = 5; lim[3] = 9;
        for (int i = 0; i < 4; i++) begin
            d[i] = int'(p[15-4*i -: 4]);
            if (d[i] > lim[i]) d[i] = lim[i];
        end
        return (d[0] * 10 + d[1]) * 60 + d[2] * 10 + d[3];
    endfunction

    function automatic logic [15:0] to_bcd(input int s);
        int mm, ss;
        mm = s / 60;
        ss = s % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    task automatic model_step();
        bit tk;
        m_wrap = 1'b0;
        if (rst) begin
            m_state = S_IDLE; m_secs = 0; m_cap = 0; m_psc = 0; m_acnt = 0;
            m_mode = 1'b0; m_lap = 1'b0; m_alarm = 1'b0; m_led = 1'b0;
            return;
        end
        case (m_state)
            S_IDLE: begin
                m_psc = 0;
                if (clear) m_secs = 0;
                else if (load) m_secs = clamp_secs(preset);
                else if (start && !(mode && m_secs == 0)) begin
                    m_state = S_RUN;
                    m_mode  = mode;
                end
            end
            S_RUN: begin
                if (clear) begin
                    m_state = S_IDLE; m_secs = 0; m_psc = 0; m_lap = 1'b0;
                end else begin
                    tk = (m_psc == DIV - 1);
                    m_psc = tk ? 0 : m_psc + 1;
                    if (pause) m_state = S_PAUSE;
                    else if (lap) begin
                        if (m_lap) m_lap = 1'b0;
                        else begin m_lap = 1'b1; m_cap = m_secs; end
                    end
                    if (tk) begin
                        m_led = !m_led;
                        if (!m_mode) begin
                            if (m_secs == 3599) begin m_secs = 0; m_wrap = 1'b1; end
                            else m_secs++;
                        end else if (m_secs == 0) begin
                            m_state = S_DONE; m_alarm = 1'b1; m_acnt = 0; m_lap = 1'b0;
                        end else begin
                            m_secs--;
                        end
                    end
                end
            end
            S_PAUSE: begin
                if (clear || load) begin
                    m_state = S_IDLE;
                    m_secs  = clear ? 0 : clamp_secs(preset);
                    m_psc   = 0;
                    m_lap   = 1'b0;
                end else if (start) begin
                    m_state = S_RUN;
                end
            end
            default: begin
                if (clear || load) begin
                    m_state = S_IDLE;
                    m_secs  = clear ? 0 : clamp_secs(preset);
                    m_psc   = 0;
                    m_alarm = 1'b0;
                    m_acnt  = 0;
                end else begin
                    tk = (m_psc == DIV - 1);
                    m_psc = tk ? 0 : m_psc + 1;
                    if (tk) begin
                        m_led = !m_led;
                        if (m_alarm) begin
                            m_acnt++;
                            if (m_acnt == ALARM_TICKS) m_alarm = 1'b0;
                        end
                    end
                end
            end
        endcase
    endtask

    // One clock: predict, let the edge happen, queue the prediction, drop the pulses.
    task automatic cyc();
        exp_t e;
        model_step();
        e.digits     = to_bcd(m_lap ? m_cap : m_secs);
        e.state      = 2'(m_state);
        e.running    = (m_state == S_RUN);
        e.wrap       = m_wrap;
        e.alarm      = m_alarm;
        e.lap_active = m_lap;
        e.tick_led   = m_led;
        @(posedge clk);
        #1;
        sb_q.push_back(e);
        start = 1'b0; pause = 1'b0; clear = 1'b0; load = 1'b0; lap = 1'b0;
    endtask

    // Monitor: compare the DUT against each queued prediction away from the active edge.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("sb_digits", 32'(digits), 32'(e.digits));
            check("sb_state",  32'(state),  32'(e.state));
            check("sb_flags",  32'({running, wrap, alarm, lap_active, tick_led}),
                               32'({e.running, e.wrap, e.alarm, e.lap_active, e.tick_led}));
        end
    end

    function automatic logic [15:0] pick_preset();
        logic [15:0] r;
        r = 16'($urandom);
        case ($urandom_range(0, 3))
            0:       return {12'h000, 4'($urandom_range(0, 9))};
            1:       return ($urandom_range(0, 1) == 0) ? 16'h5958 : 16'h5959;
            2:       return {8'h00, 4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
            default: return r;
        endcase
    endfunction

    initial begin
        // Reset
        rst = 1'b1;
        repeat (3) cyc();
        rst = 1'b0;
        cyc();
        check("reset_digits", 32'(digits), 32'h0000);
        check("reset_state",  32'(state),  32'h0);

        // One minute of counting up
        mode = 1'b0; start = 1'b1; cyc();
        repeat (600) cyc();
        check("up_600_digits",  32'(digits),  32'h0100);
        check("up_600_state",   32'(state),   32'h1);
        check("up_600_running", 32'(running), 32'h1);

        // 59:59 rolls over to 00:00 with a single wrap pulse
        clear = 1'b1; cyc();
        preset = 16'h5959; load = 1'b1; cyc();
        check("load_5959", 32'(digits), 32'h5959);
        start = 1'b1; cyc();
        repeat (9) cyc();
        check("pre_wrap_digits", 32'(digits), 32'h5959);
        check("pre_wrap_pulse",  32'(wrap),   32'h0);
        cyc();
        check("wrap_digits", 32'(digits), 32'h0000);
        check("wrap_pulse",  32'(wrap),   32'h1);
        check("wrap_state",  32'(state),  32'h1);
        cyc();
        check("wrap_one_cycle", 32'(wrap), 32'h0);

        // Countdown from 00:03, expiry and alarm window
        clear = 1'b1; cyc();
        preset = 16'h0003; load = 1'b1; cyc();
        mode = 1'b1; start = 1'b1; cyc();
        repeat (30) cyc();
        check("down_zero_digits", 32'(digits), 32'h0000);
        check("down_zero_state",  32'(state),  32'h1);
        repeat (10) cyc();
        check("done_state", 32'(state), 32'h3);
        check("done_alarm", 32'(alarm), 32'h1);
        repeat (19) cyc();
        check("alarm_still_high", 32'(alarm), 32'h1);
        cyc();
        check("alarm_dropped", 32'(alarm), 32'h0);

        // Pause keeps the fractional second
        clear = 1'b1; cyc();
        mode = 1'b0; start = 1'b1; cyc();
        repeat (24) cyc();
        pause = 1'b1; cyc();
        check("pause_digits", 32'(digits), 32'h0002);
        check("pause_state",  32'(state),  32'h2);
        repeat (100) cyc();
        check("pause_hold", 32'(digits), 32'h0002);
        start = 1'b1; cyc();
        repeat (4) cyc();
        check("resume_before_tick", 32'(digits), 32'h0002);
        cyc();
        check("resume_tick", 32'(digits), 32'h0003);

        // Lap freeze while counting continues
        repeat (20) cyc();
        check("lap_pre", 32'(digits), 32'h0005);
        lap = 1'b1; cyc();
        repeat (30) cyc();
        check("lap_frozen", 32'(digits),     32'h0005);
        check("lap_active", 32'(lap_active), 32'h1);
        lap = 1'b1; cyc();
        check("lap_release", 32'(digits),     32'h0008);
        check("lap_cleared", 32'(lap_active), 32'h0);

        // clear beats start; reset mid-run; clamped load
        clear = 1'b1; start = 1'b1; cyc();
        check("clear_start_state",  32'(state),  32'h0);
        check("clear_start_digits", 32'(digits), 32'h0000);
        start = 1'b1; cyc();
        repeat (15) cyc();
        rst = 1'b1; cyc();
        check("rst_digits", 32'(digits), 32'h0000);
        check("rst_state",  32'(state),  32'h0);
        check("rst_flags",  32'({running, wrap, alarm, lap_active, tick_led}), 32'h0);
        rst = 1'b0;
        preset = 16'hAF7C; load = 1'b1; cyc();
        check("clamp_load", 32'(digits), 32'h5959);

        // Random command traffic
        for (int i = 0; i < 5000; i++) begin
            rst   = ($urandom_range(0, 1999) == 0);
            clear = ($urandom_range(0, 249) == 0);
            load  = ($urandom_range(0, 119) == 0);
            pause = ($urandom_range(0, 89) == 0);
            start = ($urandom_range(0, 19) == 0);
            lap   = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 29) == 0) mode = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 49) == 0) preset = pick_preset();
            cyc();
        end
        rst = 1'b0;
        cyc();

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
